// File: rtl/sudoku_pkg.sv
// Scancode constants and receiver state type shared by the PS/2 command front end.
package sudoku_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    localparam logic [7:0] SC_ROW_1 = 8'h16;
    localparam logic [7:0] SC_ROW_2 = 8'h1E;
    localparam logic [7:0] SC_ROW_3 = 8'h26;
    localparam logic [7:0] SC_ROW_4 = 8'h25;
    localparam logic [7:0] SC_ROW_5 = 8'h2E;
    localparam logic [7:0] SC_ROW_6 = 8'h36;
    localparam logic [7:0] SC_ROW_7 = 8'h3D;
    localparam logic [7:0] SC_ROW_8 = 8'h3E;
    localparam logic [7:0] SC_ROW_9 = 8'h46;

    localparam logic [7:0] SC_KP_1 = 8'h69;
    localparam logic [7:0] SC_KP_2 = 8'h72;
    localparam logic [7:0] SC_KP_3 = 8'h7A;
    localparam logic [7:0] SC_KP_4 = 8'h6B;
    localparam logic [7:0] SC_KP_5 = 8'h73;
    localparam logic [7:0] SC_KP_6 = 8'h74;
    localparam logic [7:0] SC_KP_7 = 8'h6C;
    localparam logic [7:0] SC_KP_8 = 8'h75;
    localparam logic [7:0] SC_KP_9 = 8'h7D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Non-extended digit lookup; 0 means the code is not a digit key.
    function automatic logic [3:0] scan_digit(input logic [7:0] code);
        logic [3:0] d;
        d = 4'd0;
        case (code)
            SC_ROW_1, SC_KP_1: d = 4'd1;
            SC_ROW_2, SC_KP_2: d = 4'd2;
            SC_ROW_3, SC_KP_3: d = 4'd3;
            SC_ROW_4, SC_KP_4: d = 4'd4;
            SC_ROW_5, SC_KP_5: d = 4'd5;
            SC_ROW_6, SC_KP_6: d = 4'd6;
            SC_ROW_7, SC_KP_7: d = 4'd7;
            SC_ROW_8, SC_KP_8: d = 4'd8;
            SC_ROW_9, SC_KP_9: d = 4'd9;
            default:           d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM
// with odd-parity check and inactivity timeout.
module ps2_rx
    import sudoku_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       rx_error
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt;
    logic          clk_filt_q;
    logic          fe;

    rx_state_t     state;
    rx_state_t     state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          byte_valid_d;
    logic          rx_error_d;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fe     = clk_filt_q & ~clk_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered level only moves after FILTER_LEN straight samples that disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_cnt   <= '0;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_filt_q <= clk_filt;
            if (clk_s == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign timeout = (state != RX_IDLE) && (tcnt == TO_LAST);

    always_comb begin
        state_d      = state;
        byte_valid_d = 1'b0;
        rx_error_d   = 1'b0;
        if (fe) begin
            case (state)
                RX_IDLE:   if (!data_s) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (data_s && (^{shift, parity_bit}))
                        byte_valid_d = 1'b1;
                    else
                        rx_error_d = 1'b1;
                end
                default:   state_d = RX_IDLE;
            endcase
        end else if (timeout) begin
            state_d    = RX_IDLE;
            rx_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tcnt       <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            rx_error   <= 1'b0;
        end else begin
            state      <= state_d;
            byte_valid <= byte_valid_d;
            rx_error   <= rx_error_d;
            if (byte_valid_d)
                byte_data <= shift;
            // tcnt holds the number of cycles elapsed since the most recent falling edge.
            if (fe)
                tcnt <= TW'(1);
            else if (state != RX_IDLE)
                tcnt <= tcnt + TW'(1);
            else
                tcnt <= '0;
            if (fe) begin
                case (state)
                    RX_IDLE: bit_cnt <= '0;
                    RX_DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= data_s;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Set-2 scancode decoder turning PS/2 key makes into one-cycle game commands.
module ps2_cmd_decoder
    import sudoku_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] cmd_number,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_enter,
    output logic       cmd_valid,
    output logic       rx_error
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ext;
    logic       brk;
    logic       is_prefix;
    logic [3:0] num_d;
    logic       up_d;
    logic       down_d;
    logic       left_d;
    logic       right_d;
    logic       enter_d;
    logic       valid_d;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .rx_error   (rx_error)
    );

    assign is_prefix = (byte_data == SC_EXT) || (byte_data == SC_BRK);

    always_comb begin
        num_d   = '0;
        up_d    = 1'b0;
        down_d  = 1'b0;
        left_d  = 1'b0;
        right_d = 1'b0;
        enter_d = 1'b0;
        if (byte_valid && !is_prefix && !brk) begin
            if (ext) begin
                case (byte_data)
                    SC_UP:    up_d    = 1'b1;
                    SC_DOWN:  down_d  = 1'b1;
                    SC_LEFT:  left_d  = 1'b1;
                    SC_RIGHT: right_d = 1'b1;
                    SC_ENTER: enter_d = 1'b1;
                    default: ;
                endcase
            end else if (byte_data == SC_ENTER) begin
                enter_d = 1'b1;
            end else begin
                num_d = scan_digit(byte_data);
            end
        end
        valid_d = up_d | down_d | left_d | right_d | enter_d | (num_d != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == SC_EXT) begin
                ext <= 1'b1;
            end else if (byte_data == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_number <= '0;
            cmd_up     <= 1'b0;
            cmd_down   <= 1'b0;
            cmd_left   <= 1'b0;
            cmd_right  <= 1'b0;
            cmd_enter  <= 1'b0;
            cmd_valid  <= 1'b0;
        end else begin
            cmd_number <= num_d;
            cmd_up     <= up_d;
            cmd_down   <= down_d;
            cmd_left   <= left_d;
            cmd_right  <= right_d;
            cmd_enter  <= enter_d;
            cmd_valid  <= valid_d;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Scoreboard bench for ps2_cmd_decoder: serialises PS/2 frames and checks command value and latency.
module tb_ps2_cmd_decoder;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    localparam logic [8:0] C_UP    = 9'b0000_10000;
    localparam logic [8:0] C_DOWN  = 9'b0000_01000;
    localparam logic [8:0] C_LEFT  = 9'b0000_00100;
    localparam logic [8:0] C_RIGHT = 9'b0000_00010;
    localparam logic [8:0] C_ENTER = 9'b0000_00001;
    localparam logic [8:0] C_NONE  = 9'b0;

    typedef struct {
        logic [8:0] cmd;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] cmd_number;
    logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_valid, rx_error;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_cmd = 0;
    int   n_exp = 0;
    int   n_err = 0;
    int   idle_bad = 0;
    int   last_err_cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [8:0] obs;

    ps2_cmd_decoder #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .cmd_number (cmd_number),
        .cmd_up     (cmd_up),
        .cmd_down   (cmd_down),
        .cmd_left   (cmd_left),
        .cmd_right  (cmd_right),
        .cmd_enter  (cmd_enter),
        .cmd_valid  (cmd_valid),
        .rx_error   (rx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [8:0] dig(input int n);
        return {4'(n), 5'b0};
    endfunction

    // Commands are popped and compared as soon as the DUT strobes them.
    always @(negedge clk) begin
        if (!reset) begin
            obs = {cmd_number, cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter};
            if (cmd_valid) begin
                n_cmd++;
                check("cmd_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("cmd_value", 32'(obs), 32'(mon_e.cmd));
                    check("cmd_latency", 32'(cyc), 32'(mon_e.cyc));
                end
            end else if (obs != '0) begin
                idle_bad++;
            end
            if (rx_error) begin
                n_err++;
                last_err_cyc = cyc;
            end
        end
    end

    // One PS/2 bit: data set while clock high, then a low half-period; optional 2-cycle glitch.
    task automatic ps2_bit(input logic b, input bit glitch, input logic [8:0] exp, output int fall_cyc);
        ps2_data = b;
        if (glitch) begin
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2 - 2) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        if (exp != C_NONE) begin
            sb.push_back('{exp, cyc + FL + 4});
            n_exp++;
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch,
                             input logic [8:0] exp, output int stop_cyc);
        int   fc;
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        ps2_bit(1'b0, glitch, C_NONE, fc);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch, C_NONE, fc);
        ps2_bit(p, glitch, C_NONE, fc);
        ps2_bit(1'b1, glitch, exp, stop_cyc);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b, input logic [8:0] exp);
        int sc;
        send_byte(b, 1'b0, 1'b0, exp, sc);
    endtask

    initial begin
        int         sc;
        int         fc;
        int         e0;
        logic [7:0] pat;

        repeat (5) @(negedge clk);
        check("reset_outs", 32'({cmd_valid, cmd_number, cmd_up, cmd_down, cmd_left,
                                 cmd_right, cmd_enter, rx_error}), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        key(8'h1E, dig(2));
        key(8'hE0, C_NONE);
        key(8'h75, C_UP);
        key(8'hE0, C_NONE);
        key(8'hF0, C_NONE);
        key(8'h75, C_NONE);
        check("release_no_err", 32'(n_err), 32'd0);

        key(8'h72, dig(2));
        key(8'hE0, C_NONE);
        key(8'h72, C_DOWN);
        key(8'h5A, C_ENTER);
        key(8'hE0, C_NONE);
        key(8'h5A, C_ENTER);
        key(8'hE0, C_NONE);
        key(8'h74, C_RIGHT);
        key(8'h7D, dig(9));
        key(8'h2E, dig(5));
        key(8'h1C, C_NONE);
        key(8'h1E, dig(2));
        key(8'h1E, dig(2));

        send_byte(8'h26, 1'b1, 1'b0, C_NONE, sc);
        check("parity_err_cnt", 32'(n_err), 32'd1);
        check("parity_err_lat", 32'(last_err_cyc), 32'(sc + FL + 3));
        key(8'h26, dig(3));

        e0  = n_err;
        pat = 8'hA5;
        ps2_bit(1'b0, 1'b0, C_NONE, fc);
        for (int i = 0; i < 4; i++) ps2_bit(pat[i], 1'b0, C_NONE, fc);
        ps2_data = 1'b1;
        repeat (TO + 50) @(negedge clk);
        check("timeout_err_cnt", 32'(n_err), 32'(e0 + 1));
        check("timeout_err_lat", 32'(last_err_cyc), 32'(fc + FL + 2 + TO));
        key(8'hE0, C_NONE);
        key(8'h6B, C_LEFT);

        send_byte(8'h46, 1'b0, 1'b1, dig(9), sc);

        e0  = n_err;
        pat = 8'h46;
        ps2_bit(1'b0, 1'b0, C_NONE, fc);
        for (int i = 0; i < 3; i++) ps2_bit(pat[i], 1'b0, C_NONE, fc);
        ps2_data = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_outs", 32'({cmd_valid, cmd_number, cmd_up, cmd_down, cmd_left,
                                    cmd_right, cmd_enter, rx_error}), 32'd0);
        reset = 1'b0;
        repeat (TO + 100) @(negedge clk);
        check("midreset_no_err", 32'(n_err), 32'(e0));
        key(8'h16, dig(1));

        repeat (200) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("cmd_count", 32'(n_cmd), 32'(n_exp));
        check("err_total", 32'(n_err), 32'd2);
        check("idle_outs_zero", 32'(idle_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
